// File: rtl/msk_mux_skid_pkg.sv
// Shared helpers for the masked mux/skid slice: select width and share-interleaved bus indexing.
// A bus holds count bits per share; bit i of share j sits at i*d+j.
package msk_mux_skid_pkg;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int share_bit_idx(input int bit_i, input int share_j, input int n_shares);
    return bit_i * n_shares + share_j;
  endfunction

  function automatic int bus_base(input int bus_k, input int bus_w);
    return bus_k * bus_w;
  endfunction

endpackage

// File: rtl/msk_mux_skid_sel.sv
// Combinational per-share nin:1 masked mux; zero-latency, no backpressure (pure logic).
// Out-of-range selects yield all-zero data with selerr_o set.
module msk_mux_sel
  import msk_mux_skid_pkg::*;
#(
  parameter int d     = 2,
  parameter int count = 8,
  parameter int nin   = 4,
  localparam int SELW = sel_width(nin),
  localparam int W    = count * d
) (
  input  logic [nin*W-1:0] in_data_i,
  input  logic [SELW-1:0]  sel_i,
  output logic [W-1:0]     dat_o,
  output logic             selerr_o
);

  // Each output bit picks the same share bit of the chosen bus; shares never mix.
  always_comb begin
    dat_o    = '0;
    selerr_o = (32'(sel_i) >= 32'(nin));
    for (int k = 0; k < nin; k++) begin
      if (sel_i == SELW'(k)) begin
        for (int j = 0; j < d; j++) begin
          for (int i = 0; i < count; i++) begin
            dat_o[share_bit_idx(i, j, d)] = in_data_i[bus_base(k, W) + share_bit_idx(i, j, d)];
          end
        end
      end
    end
  end

endmodule

// File: rtl/msk_mux_skid.sv
// Masked N:1 mux into a 2-entry skid buffer; 1-cycle in_fire->out_valid latency, full rate.
// in_ready is registered and drops only when the skid entry is occupied.
module msk_mux_skid
  import msk_mux_skid_pkg::*;
#(
  parameter int d     = 2,
  parameter int count = 8,
  parameter int nin   = 4,
  localparam int SELW = sel_width(nin),
  localparam int W    = count * d
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SELW-1:0]   in_sel,
  input  logic [nin*W-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic              out_selerr
);

  typedef struct packed {
    logic [W-1:0] dat;
    logic         selerr;
  } beat_t;

  logic [W-1:0] sel_dat;
  logic         sel_err;
  beat_t        sel_beat;
  beat_t        m_q, m_d, s_q, s_d;
  logic         m_vld_q, m_vld_d, s_vld_q, s_vld_d, rdy_q, rdy_d;
  logic         in_fire, out_fire, m_free, m_ld_s, m_ld_in, s_ld_in;

  (* keep_hierarchy = "yes", dont_touch = "yes" *)
  msk_mux_sel #(
    .d     (d),
    .count (count),
    .nin   (nin)
  ) u_sel (
    .in_data_i (in_data),
    .sel_i     (in_sel),
    .dat_o     (sel_dat),
    .selerr_o  (sel_err)
  );

  assign sel_beat = '{dat: sel_dat, selerr: sel_err};
  assign in_fire  = in_valid & rdy_q;
  assign out_fire = m_vld_q & out_ready;

  always_comb begin
    m_free  = !m_vld_q || out_fire;
    m_ld_s  = m_free && s_vld_q;
    m_ld_in = m_free && !s_vld_q && in_fire;
    s_ld_in = in_fire && !m_ld_in;

    m_d     = m_q;
    s_d     = s_q;
    m_vld_d = m_vld_q;
    s_vld_d = s_vld_q;

    if (m_free) begin
      m_vld_d = s_vld_q || in_fire;
    end
    if (m_ld_s) begin
      m_d = s_q;
    end else if (m_ld_in) begin
      m_d = sel_beat;
    end

    // S drains into M and refills from the input in the same cycle when both happen.
    if (s_ld_in) begin
      s_d     = sel_beat;
      s_vld_d = 1'b1;
    end else if (m_ld_s) begin
      s_vld_d = 1'b0;
    end

    rdy_d = !s_vld_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q     <= '0;
      s_q     <= '0;
      m_vld_q <= 1'b0;
      s_vld_q <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      m_q     <= m_d;
      s_q     <= s_d;
      m_vld_q <= m_vld_d;
      s_vld_q <= s_vld_d;
      rdy_q   <= rdy_d;
    end
  end

  assign in_ready   = rdy_q;
  assign out_valid  = m_vld_q;
  assign out_data   = m_q.dat;
  assign out_selerr = m_q.selerr;

endmodule

// File: tb/tb_msk_mux_skid.sv
// Bench for msk_mux_skid: nin=4 and nin=5 instances against a queue-based reference model.
module tb_msk_mux_skid;
  localparam int W = 16;

  typedef struct {
    logic [W-1:0] dat;
    bit           err;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, out_valid, out_ready, out_selerr;
  logic [1:0]    in_sel;
  logic [4*W-1:0] in_data;
  logic [W-1:0]  out_data;

  logic          in_valid5, in_ready5, out_valid5, out_ready5, out_selerr5;
  logic [2:0]    in_sel5;
  logic [5*W-1:0] in_data5;
  logic [W-1:0]  out_data5;

  msk_mux_skid #(.d(2), .count(8), .nin(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_selerr(out_selerr)
  );

  msk_mux_skid #(.d(2), .count(8), .nin(5)) u_dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5), .in_sel(in_sel5),
    .in_data(in_data5), .out_valid(out_valid5), .out_ready(out_ready5), .out_data(out_data5),
    .out_selerr(out_selerr5)
  );

  int vectors = 0;
  int miscompares = 0;

  beat_t q4[$], q5[$];
  bit rdy4 = 0, rdy5 = 0;
  bit fired4, fired5;
  logic [W-1:0] got4[$];

  // Reference selection: the chosen bus verbatim, or zero with an error flag when out of range.
  function automatic beat_t ref_sel(logic [5*W-1:0] data, int sel, int n);
    beat_t b;
    if (sel >= n) begin
      b.dat = '0;
      b.err = 1'b1;
    end else begin
      b.dat = data[sel*W +: W];
      b.err = 1'b0;
    end
    return b;
  endfunction

  // Advance one clock; the model is a FIFO of at most two accepted beats.
  task automatic cycle();
    bit    f4_in, f4_out, f5_in, f5_out;
    beat_t b4, b5;
    f4_in  = in_valid && rdy4;
    f4_out = (q4.size() > 0) && out_ready;
    f5_in  = in_valid5 && rdy5;
    f5_out = (q5.size() > 0) && out_ready5;
    b4 = ref_sel({{W{1'b0}}, in_data}, int'(in_sel), 4);
    b5 = ref_sel(in_data5, int'(in_sel5), 5);
    if (out_valid && out_ready) got4.push_back(out_data);
    @(posedge clk);
    #1;
    if (rst) begin
      q4.delete();
      q5.delete();
      rdy4 = 0;
      rdy5 = 0;
      fired4 = 0;
      fired5 = 0;
    end else begin
      if (f4_out) void'(q4.pop_front());
      if (f4_in) q4.push_back(b4);
      if (f5_out) void'(q5.pop_front());
      if (f5_in) q5.push_back(b5);
      rdy4 = q4.size() < 2;
      rdy5 = q5.size() < 2;
      fired4 = f4_in;
      fired5 = f5_in;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_sel = 2'd1;
    in_data = {4{16'hBEEF}};
    out_ready = 1'b1;
    in_valid5 = 1'b1;
    in_sel5 = 3'd0;
    in_data5 = {5{16'h1234}};
    out_ready5 = 1'b1;
    for (int c = 0; c < 2; c++) begin
      cycle();
      vectors++;
      if ({out_valid, out_data, out_selerr, in_ready, out_valid5, in_ready5} !== {1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL reset_hold cyc=%0d: vld=%b dat=%h err=%b rdy=%b vld5=%b rdy5=%b, want all zero",
                 c, out_valid, out_data, out_selerr, in_ready, out_valid5, in_ready5);
      end
    end
    rst = 1'b0;
    in_valid = 1'b0;
    in_valid5 = 1'b0;
    cycle();
    vectors++;
    if ({in_ready, out_valid, in_ready5, out_valid5} !== 4'b1010) begin
      miscompares++;
      $display("FAIL reset_release: rdy=%b vld=%b rdy5=%b vld5=%b, want rdy=1 vld=0",
               in_ready, out_valid, in_ready5, out_valid5);
    end
  endtask

  task automatic test_single();
    in_data = {16'hFFFF, 16'hA55A, 16'hFFFF, 16'hFFFF};
    in_sel = 2'd2;
    in_valid = 1'b1;
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    vectors++;
    if ({out_valid, out_data, out_selerr} !== {1'b1, 16'hA55A, 1'b0}) begin
      miscompares++;
      $display("FAIL single_beat: vld=%b dat=%h err=%b, want 1 a55a 0", out_valid, out_data, out_selerr);
    end
    cycle();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_drain: vld=%b, want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] pat[3];
    int n;
    pat[0] = 16'h1111;
    pat[1] = 16'h2222;
    pat[2] = 16'h3333;
    got4.delete();
    out_ready = 1'b0;
    n = 0;
    for (int c = 0; c < 3; c++) begin
      in_sel = 2'($urandom_range(0, 3));
      in_data = {$urandom, $urandom};
      in_data[int'(in_sel)*W +: W] = pat[n];
      in_valid = 1'b1;
      cycle();
      if (fired4) n++;
      vectors++;
      if ({out_valid, in_ready} !== {q4.size() > 0, rdy4} ||
          (out_valid && {out_data, out_selerr} !== {q4[0].dat, q4[0].err})) begin
        miscompares++;
        $display("FAIL backpressure_fill cyc=%0d: vld=%b rdy=%b dat=%h, want rdy=%b dat=%h",
                 c, out_valid, in_ready, out_data, rdy4, q4[0].dat);
      end
    end
    vectors++;
    if ({n, in_ready, out_data} !== {32'd2, 1'b0, 16'h1111}) begin
      miscompares++;
      $display("FAIL backpressure_stall: accepted=%0d rdy=%b dat=%h, want 2 0 1111", n, in_ready, out_data);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 10 && got4.size() < 3; c++) begin
      if (n < 3) begin
        in_sel = 2'($urandom_range(0, 3));
        in_data = {$urandom, $urandom};
        in_data[int'(in_sel)*W +: W] = pat[n];
      end
      in_valid = (n < 3);
      cycle();
      if (fired4) n++;
      vectors++;
      if ({out_valid, in_ready} !== {q4.size() > 0, rdy4} ||
          (out_valid && {out_data, out_selerr} !== {q4[0].dat, q4[0].err})) begin
        miscompares++;
        $display("FAIL backpressure_drain cyc=%0d: vld=%b rdy=%b dat=%h", c, out_valid, in_ready, out_data);
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (got4.size() != 3) begin
      miscompares++;
      $display("FAIL backpressure_count: got %0d beats, want 3", got4.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (got4[k] !== pat[k]) begin
          miscompares++;
          $display("FAIL backpressure_order idx=%0d: got %h want %h", k, got4[k], pat[k]);
        end
      end
    end
  endtask

  task automatic test_stream();
    beat_t b;
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      in_sel = 2'(c % 4);
      in_data = {$urandom, $urandom};
      in_valid = 1'b1;
      b = ref_sel({{W{1'b0}}, in_data}, c % 4, 4);
      cycle();
      vectors++;
      if ({out_valid, out_data, out_selerr, in_ready} !== {1'b1, b.dat, b.err, 1'b1}) begin
        miscompares++;
        $display("FAIL stream cyc=%0d: vld=%b dat=%h err=%b rdy=%b, want 1 %h %b 1",
                 c, out_valid, out_data, out_selerr, in_ready, b.dat, b.err);
      end
    end
    in_valid = 1'b0;
    cycle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_sel = 2'($urandom_range(0, 3));
      in_data = {$urandom, $urandom};
      cycle();
      vectors++;
      if ({out_valid, in_ready} !== {q4.size() > 0, rdy4} ||
          (out_valid && {out_data, out_selerr} !== {q4[0].dat, q4[0].err})) begin
        miscompares++;
        $display("FAIL random cyc=%0d: vld=%b rdy=%b dat=%h, want vld=%b rdy=%b dat=%h",
                 c, out_valid, in_ready, out_data, q4.size() > 0, rdy4, q4[0].dat);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycle();
    cycle();
  endtask

  task automatic test_selerr();
    logic [W-1:0] bus4;
    out_ready5 = 1'b1;
    in_data5 = {$urandom, $urandom, 16'($urandom)};
    in_sel5 = 3'd6;
    in_valid5 = 1'b1;
    cycle();
    vectors++;
    if ({out_valid5, out_data5, out_selerr5} !== {1'b1, 16'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL selerr_oob: vld=%b dat=%h err=%b, want 1 0000 1", out_valid5, out_data5, out_selerr5);
    end
    in_data5 = {$urandom, $urandom, 16'($urandom)};
    bus4 = in_data5[4*W +: W];
    in_sel5 = 3'd4;
    cycle();
    in_valid5 = 1'b0;
    vectors++;
    if ({out_valid5, out_data5, out_selerr5} !== {1'b1, bus4, 1'b0}) begin
      miscompares++;
      $display("FAIL selerr_bus4: vld=%b dat=%h err=%b, want 1 %h 0", out_valid5, out_data5, out_selerr5, bus4);
    end
    cycle();
  endtask

  task automatic test_reset_mid();
    beat_t b;
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      in_sel = 2'($urandom_range(0, 3));
      in_data = {$urandom, $urandom};
      cycle();
    end
    vectors++;
    if ({out_valid, in_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL midrst_full: vld=%b rdy=%b, want 1 0", out_valid, in_ready);
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    in_valid = 1'b0;
    vectors++;
    if ({out_valid, out_data, out_selerr, in_ready} !== {1'b0, 16'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL midrst_clear: vld=%b dat=%h err=%b rdy=%b, want all zero",
               out_valid, out_data, out_selerr, in_ready);
    end
    cycle();
    in_sel = 2'd1;
    in_data = {$urandom, $urandom};
    b = ref_sel({{W{1'b0}}, in_data}, 1, 4);
    in_valid = 1'b1;
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    vectors++;
    if ({out_valid, out_data, out_selerr} !== {1'b1, b.dat, 1'b0}) begin
      miscompares++;
      $display("FAIL midrst_newbeat: vld=%b dat=%h, want 1 %h", out_valid, out_data, b.dat);
    end
    cycle();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_stale: vld=%b after drain, want 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_stream();
    test_random();
    test_selerr();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
